mdio_master: RTL

IEEE 802.3 Clause 22 station-management (MDC/MDIO) initiator for the GigE front-end PHYs. It takes single read or write commands from fabric logic and serialises them onto MDC/MDIO. It returns read data and a turnaround-error flag. One instance per PHY sits beside `phy_init` and replaces the static `mdc = 0` / `mio = z` tie-offs. The top level builds the tristate from `mdio_o`/`mdio_oe`.

---
 rtl/mdio_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDC/MDIO initiator. Serialises one read
// or write command at a time and returns read data plus a turnaround-error
// flag. The pad tristate is built outside from mdio_o / mdio_oe.
// Build option: define MDIO_PREAMBLE_SUPPRESS_EN to send the 32-bit preamble
// only on the first frame after reset; later frames start at the header.
module mdio_master #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk_50,
  input  logic        reset_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_TA   = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Phase counter spans one full bit period (2*CLK_DIV cycles).
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);     // last low cycle
  localparam logic [PW-1:0] PH_SAMP = PW'(CLK_DIV);         // first high cycle
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1); // last cycle of bit

  logic [2:0]    state;
  logic [PW-1:0] ph;
  logic [4:0]    bit_cnt;
  logic          wr_q;
  logic [13:0]   hdr_q;   // ST, OP, PHYAD, REGAD; MSB is the bit on the wire
  logic [15:0]   data_q;  // write data shifting out, or read data shifting in
  logic          err_q;
  logic          sync1, sync2;
  logic          skip_pre;
  logic [13:0]   hdr_new;

  assign hdr_new = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr};

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic pre_done;

  // Remember that a preamble-bearing frame has gone out since reset.
  always_ff @(posedge clk_50) begin
    if (reset_i)
      pre_done <= 1'b0;
    else if (state == S_IDLE && cmd_valid)
      pre_done <= 1'b1;
  end

  assign skip_pre = pre_done;
`else
  assign skip_pre = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous MDIO pin.
  always_ff @(posedge clk_50) begin
    sync1 <= mdio_i;
    sync2 <= sync1;
  end

  // Frame sequencer: bit timing, shift registers and registered pin outputs.
  always_ff @(posedge clk_50) begin
    if (reset_i) begin
      state     <= S_IDLE;
      ph        <= '0;
      bit_cnt   <= '0;
      wr_q      <= 1'b0;
      hdr_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // Latch every field now; the inputs are free to change afterwards.
            wr_q      <= cmd_write;
            hdr_q     <= hdr_new;
            data_q    <= cmd_write ? cmd_wdata : 16'h0000;
            ph        <= '0;
            bit_cnt   <= '0;
            cmd_ready <= 1'b0;
            mdc       <= 1'b0;
            mdio_oe   <= 1'b1;
            state     <= skip_pre ? S_HDR : S_PRE;
            mdio_o    <= skip_pre ? hdr_new[13] : 1'b1;
          end
        end
        S_PRE, S_HDR, S_TA, S_DATA: begin
          ph <= ph + 1'b1;
          if (ph == PH_RISE)
            mdc <= 1'b1;
          // Sample one full bit period after the PHY launched on the previous rise.
          if (ph == PH_SAMP) begin
            if (state == S_TA && bit_cnt == 5'd1)
              err_q <= sync2;
            if (state == S_DATA && !wr_q)
              data_q <= {data_q[14:0], sync2};
          end
          if (ph == PH_LAST) begin
            // Bit boundary: MDC falls and the next bit's drive is launched.
            ph  <= '0;
            mdc <= 1'b0;
            case (state)
              S_PRE: begin
                if (bit_cnt == 5'd31) begin
                  state   <= S_HDR;
                  bit_cnt <= '0;
                  mdio_o  <= hdr_q[13];
                end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                  mdio_o  <= 1'b1;
                end
              end
              S_HDR: begin
                if (bit_cnt == 5'd13) begin
                  state   <= S_TA;
                  bit_cnt <= '0;
                  mdio_o  <= 1'b1;
                  mdio_oe <= wr_q;
                end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                  hdr_q   <= {hdr_q[12:0], 1'b0};
                  mdio_o  <= hdr_q[12];
                end
              end
              S_TA: begin
                if (bit_cnt == 5'd0) begin
                  bit_cnt <= 5'd1;
                  mdio_o  <= 1'b0;
                end else begin
                  state   <= S_DATA;
                  bit_cnt <= '0;
                  mdio_o  <= wr_q ? data_q[15] : 1'b1;
                  mdio_oe <= wr_q;
                end
              end
              default: begin
                if (bit_cnt == 5'd15) begin
                  state     <= S_DONE;
                  bit_cnt   <= '0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= wr_q ? 16'h0000 : data_q;
                  rsp_error <= wr_q ? 1'b0 : err_q;
                  mdio_o    <= 1'b1;
                  mdio_oe   <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                  if (wr_q) begin
                    data_q <= {data_q[14:0], 1'b0};
                    mdio_o <= data_q[14];
                  end
                end
              end
            endcase
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          mdc       <= 1'b0;
          mdio_oe   <= 1'b0;
        end
      endcase
    end
  end

endmodule
